// File: rtl/mic_datapath_p.sv
// MIC-1 style datapath with parametrised width and handshaked memory ports.
// Holds the register file, B-bus decode, ALU, shifter, N/Z flags and the
// next-microaddress jam logic. A data port (MAR/MDR) and an instruction port
// (PC/MBR) each carry one outstanding request; issuing a new op on a busy,
// un-acked port raises stall and suppresses the whole microinstruction.
module mic_datapath_p #(
  parameter int W  = 32,
  parameter int IW = 8,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr_next,
  input  logic [2:0]    jam,
  input  logic [7:0]    alu_ctrl,
  input  logic [8:0]    c_sel,
  input  logic [2:0]    mem,
  input  logic [3:0]    b_sel,
  output logic [AW-1:0] next_addr,
  output logic          stall,
  output logic [W-1:0]  dmem_addr,
  output logic [W-1:0]  dmem_wdata,
  output logic          dmem_rd,
  output logic          dmem_wr,
  input  logic [W-1:0]  dmem_rdata,
  input  logic          dmem_ack,
  output logic [W-1:0]  imem_addr,
  output logic          imem_rd,
  input  logic [IW-1:0] imem_rdata,
  input  logic          imem_ack
);

  // Register file
  logic [W-1:0]  mar_q, mdr_q, pc_q, sp_q, lv_q, cpp_q, tos_q, opc_q, h_q;
  logic [W-1:0]  mar_d, mdr_d, pc_d, sp_d, lv_d, cpp_d, tos_d, opc_d, h_d;
  logic [IW-1:0] mbr_q, mbr_d;
  logic          n_q, n_d, z_q, z_d;

  // Port request registers (double as pending flags)
  logic          drd_q, drd_d, dwr_q, dwr_d, ird_q, ird_d;

  // Combinational datapath
  logic [W-1:0]  busb, alu_a, alu_b, alu_out, busc;
  logic          d_op, i_op, go;

  // Microinstruction field aliases
  logic sll8, sra1, f0, f1, ena, enb, inva, inc;
  assign {sll8, sra1, f0, f1, ena, enb, inva, inc} = alu_ctrl;

  // B-bus source select; MBR is sign- or zero-extended to datapath width
  always_comb begin
    busb = '0;
    case (b_sel)
      4'd0:    busb = mdr_q;
      4'd1:    busb = pc_q;
      4'd2:    busb = {{(W-IW){mbr_q[IW-1]}}, mbr_q};
      4'd3:    busb = {{(W-IW){1'b0}}, mbr_q};
      4'd4:    busb = sp_q;
      4'd5:    busb = lv_q;
      4'd6:    busb = cpp_q;
      4'd7:    busb = tos_q;
      4'd8:    busb = opc_q;
      default: busb = '0;
    endcase
  end

  // ALU operand gating, function select and the shifter feeding the C-bus
  always_comb begin
    alu_a = ena ? h_q : '0;
    if (inva) begin
      alu_a = ~alu_a;
    end else begin
      alu_a = alu_a;
    end
    alu_b = enb ? busb : '0;
    case ({f0, f1})
      2'b00:   alu_out = alu_a & alu_b;
      2'b01:   alu_out = alu_a | alu_b;
      2'b10:   alu_out = ~alu_b;
      default: alu_out = alu_a + alu_b + {{(W-1){1'b0}}, inc};
    endcase
    busc = alu_out;
    if (sll8) begin
      busc = {busc[W-9:0], 8'h00};
    end else begin
      busc = busc;
    end
    if (sra1) begin
      busc = {busc[W-1], busc[W-1:1]};
    end else begin
      busc = busc;
    end
  end

  // Stall when a new op targets a port whose request is still outstanding
  always_comb begin
    d_op  = mem[2] | mem[1];
    i_op  = mem[0];
    stall = (d_op & (drd_q | dwr_q) & ~dmem_ack) | (i_op & ird_q & ~imem_ack);
    go    = ~stall;
  end

  // Next-state for registers, flags and port requests
  always_comb begin
    mar_d = mar_q; mdr_d = mdr_q; pc_d  = pc_q;  sp_d  = sp_q;  lv_d = lv_q;
    cpp_d = cpp_q; tos_d = tos_q; opc_d = opc_q; h_d   = h_q;   mbr_d = mbr_q;
    n_d   = n_q;   z_d   = z_q;
    drd_d = drd_q; dwr_d = dwr_q; ird_d = ird_q;
    if (go) begin
      if (c_sel[0]) mar_d = busc; else mar_d = mar_q;
      if (c_sel[1]) mdr_d = busc; else mdr_d = mdr_q;
      if (c_sel[2]) pc_d  = busc; else pc_d  = pc_q;
      if (c_sel[3]) sp_d  = busc; else sp_d  = sp_q;
      if (c_sel[4]) lv_d  = busc; else lv_d  = lv_q;
      if (c_sel[5]) cpp_d = busc; else cpp_d = cpp_q;
      if (c_sel[6]) tos_d = busc; else tos_d = tos_q;
      if (c_sel[7]) opc_d = busc; else opc_d = opc_q;
      if (c_sel[8]) h_d   = busc; else h_d   = h_q;
      n_d = alu_out[W-1];
      z_d = (alu_out == '0);
    end else begin
      n_d = n_q;
      z_d = z_q;
    end
    // A completing read overrides any C-bus write to MDR in the same cycle
    if (drd_q & dmem_ack) begin
      mdr_d = dmem_rdata;
    end else begin
      mdr_d = mdr_d;
    end
    if (ird_q & imem_ack) begin
      mbr_d = imem_rdata;
    end else begin
      mbr_d = mbr_q;
    end
    // A new issue wins over an ack so back-to-back ops keep the request high
    if (go & d_op) begin
      drd_d = mem[1] & ~mem[2];
      dwr_d = mem[2];
    end else if (dmem_ack) begin
      drd_d = 1'b0;
      dwr_d = 1'b0;
    end else begin
      drd_d = drd_q;
      dwr_d = dwr_q;
    end
    if (go & i_op) begin
      ird_d = 1'b1;
    end else if (imem_ack) begin
      ird_d = 1'b0;
    end else begin
      ird_d = ird_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mar_q <= '0; mdr_q <= '0; pc_q  <= '0; sp_q  <= '0; lv_q <= '0;
      cpp_q <= '0; tos_q <= '0; opc_q <= '0; h_q   <= '0; mbr_q <= '0;
      n_q   <= 1'b0; z_q <= 1'b0;
      drd_q <= 1'b0; dwr_q <= 1'b0; ird_q <= 1'b0;
    end else begin
      mar_q <= mar_d; mdr_q <= mdr_d; pc_q  <= pc_d;  sp_q  <= sp_d;  lv_q <= lv_d;
      cpp_q <= cpp_d; tos_q <= tos_d; opc_q <= opc_d; h_q   <= h_d;   mbr_q <= mbr_d;
      n_q   <= n_d;   z_q   <= z_d;
      drd_q <= drd_d; dwr_q <= dwr_d; ird_q <= ird_d;
    end
  end

  // Next microaddress: JMPC ORs MBR into the low bits, JAMN/JAMZ set the top bit
  always_comb begin
    next_addr = addr_next;
    if (jam[2]) begin
      next_addr = next_addr | {{(AW-IW){1'b0}}, mbr_q};
    end else begin
      next_addr = next_addr;
    end
    next_addr[AW-1] = addr_next[AW-1] | (jam[1] & n_q) | (jam[0] & z_q);
  end

  assign dmem_addr  = mar_q;
  assign dmem_wdata = mdr_q;
  assign dmem_rd    = drd_q;
  assign dmem_wr    = dwr_q;
  assign imem_addr  = pc_q;
  assign imem_rd    = ird_q;

endmodule

// File: tb/tb_mic_datapath_p.sv
// Directed self-checking bench for mic_datapath_p.
module tb_mic_datapath_p;
  localparam int W = 32, IW = 8, AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr_next;
  logic [2:0]    jam;
  logic [7:0]    alu_ctrl;
  logic [8:0]    c_sel;
  logic [2:0]    mem;
  logic [3:0]    b_sel;
  logic [AW-1:0] next_addr;
  logic          stall;
  logic [W-1:0]  dmem_addr, dmem_wdata, dmem_rdata, imem_addr;
  logic          dmem_rd, dmem_wr, dmem_ack, imem_rd, imem_ack;
  logic [IW-1:0] imem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mic_datapath_p #(.W(W), .IW(IW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .addr_next(addr_next), .jam(jam), .alu_ctrl(alu_ctrl),
    .c_sel(c_sel), .mem(mem), .b_sel(b_sel), .next_addr(next_addr), .stall(stall),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rd(dmem_rd),
    .dmem_wr(dmem_wr), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack)
  );

  // Compare one observed value against the expected one
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    addr_next = '0; jam = 3'd0; alu_ctrl = 8'h00; c_sel = 9'h000; mem = 3'd0;
    b_sel = 4'd0; dmem_ack = 1'b0; imem_ack = 1'b0; dmem_rdata = '0; imem_rdata = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic uop(input logic [3:0] b, input logic [7:0] a, input logic [8:0] c,
                     input logic [2:0] m);
    idle();
    b_sel = b; alu_ctrl = a; c_sel = c; mem = m;
  endtask

  // Put a constant into MDR through a one-wait read
  task automatic load_mdr(input logic [W-1:0] v);
    uop(4'd0, 8'h00, 9'h000, 3'b010);
    cyc();
    idle();
    dmem_ack = 1'b1; dmem_rdata = v;
    cyc();
    idle();
  endtask

  // Copy MDR into the registers selected by c
  task automatic copy_mdr(input logic [8:0] c);
    uop(4'd0, 8'h34, c, 3'b000);
    cyc();
    idle();
  endtask

  // Route a B-bus source (or H) to MAR and compare on dmem_addr
  task automatic peek(input string tag, input logic [3:0] b, input logic use_h,
                      input logic [W-1:0] exp);
    uop(b, use_h ? 8'h38 : 8'h34, 9'h001, 3'b000);
    cyc();
    chk(tag, dmem_addr, exp);
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_mar", dmem_addr, 32'h0);
    chk("rst_mdr", dmem_wdata, 32'h0);
    chk("rst_pc", imem_addr, 32'h0);
    chk("rst_req", {29'd0, dmem_rd, dmem_wr, imem_rd}, 32'h0);
    jam = 3'b011; #1;
    chk("rst_flags", {23'd0, next_addr}, 32'h0);
    chk("rst_stall", {31'd0, stall}, 32'h0);
    idle();

    // H=5 + SP=3
    load_mdr(32'd5); copy_mdr(9'h100);
    load_mdr(32'd3); copy_mdr(9'h008);
    uop(4'd4, 8'h3C, 9'h001, 3'b000); cyc();
    chk("add", dmem_addr, 32'd8);
    idle(); jam = 3'b011; addr_next = 9'h055; #1;
    chk("add_nz", {23'd0, next_addr}, 32'h055);

    // SRA1 of 0x80000000 + 0
    load_mdr(32'h8000_0000); copy_mdr(9'h100);
    load_mdr(32'h0); copy_mdr(9'h008);
    uop(4'd4, 8'h7C, 9'h001, 3'b000); cyc();
    chk("sra1", dmem_addr, 32'hC000_0000);
    idle(); jam = 3'b010; #1;
    chk("sra1_n", {23'd0, next_addr}, 32'h100);
    jam = 3'b001; #1;
    chk("sra1_z", {23'd0, next_addr}, 32'h000);

    // Zero result sets Z
    uop(4'd15, 8'h34, 9'h001, 3'b000); cyc();
    chk("zero", dmem_addr, 32'h0);
    idle(); jam = 3'b001; addr_next = 9'h023; #1;
    chk("jamz", {23'd0, next_addr}, 32'h123);

    // -H via INVA+INC, then JAMN
    load_mdr(32'd7); copy_mdr(9'h100);
    uop(4'd0, 8'h3B, 9'h001, 3'b000); cyc();
    chk("neg", dmem_addr, 32'hFFFF_FFF9);
    idle(); jam = 3'b010; addr_next = 9'h012; #1;
    chk("jamn", {23'd0, next_addr}, 32'h112);

    // Shifter: SLL8 alone and SLL8 then SRA1; N comes from the unshifted value
    load_mdr(32'h1234_5678); copy_mdr(9'h100);
    uop(4'd0, 8'hB8, 9'h001, 3'b000); cyc();
    chk("sll8", dmem_addr, 32'h3456_7800);
    load_mdr(32'h00C0_0001); copy_mdr(9'h100);
    uop(4'd0, 8'hF8, 9'h001, 3'b000); cyc();
    chk("sll8_sra1", dmem_addr, 32'hE000_0080);
    idle(); jam = 3'b010; #1;
    chk("n_preshift", {23'd0, next_addr}, 32'h000);

    // Logic functions with H=F0F00FF0, MDR=FF00FF00
    load_mdr(32'hF0F0_0FF0); copy_mdr(9'h100);
    load_mdr(32'hFF00_FF00);
    uop(4'd0, 8'h0C, 9'h001, 3'b000); cyc(); chk("and", dmem_addr, 32'hF000_0F00);
    uop(4'd0, 8'h1C, 9'h001, 3'b000); cyc(); chk("or", dmem_addr, 32'hFFF0_FFF0);
    uop(4'd0, 8'h24, 9'h001, 3'b000); cyc(); chk("notb", dmem_addr, 32'h00FF_00FF);

    // B-bus sources LV, CPP, TOS, OPC, PC and an unused code
    for (int i = 0; i < 4; i++) begin
      load_mdr(32'hA0 + 32'(i));
      copy_mdr(9'h010 << i);
    end
    for (int i = 0; i < 4; i++) begin
      peek("bsrc", 4'd5 + 4'(i), 1'b0, 32'hA0 + 32'(i));
    end
    load_mdr(32'h0BAD_0001); copy_mdr(9'h004);
    peek("bsrc_pc", 4'd1, 1'b0, 32'h0BAD_0001);
    peek("bsrc_9", 4'd9, 1'b0, 32'h0);

    // Read handshake with ack held off three cycles
    load_mdr(32'h40);
    uop(4'd0, 8'h34, 9'h001, 3'b010); cyc();
    chk("rd_addr", dmem_addr, 32'h40);
    chk("rd_req", {31'd0, dmem_rd}, 32'h1);
    idle();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rd_hold", {31'd0, dmem_rd}, 32'h1);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; #1;
    chk("rd_ackcyc", {31'd0, dmem_rd}, 32'h1);
    cyc();
    chk("rd_data", dmem_wdata, 32'hDEAD_BEEF);
    chk("rd_drop", {31'd0, dmem_rd}, 32'h0);
    idle();

    // READ+WRITE together is a write; a write ack leaves MDR alone
    uop(4'd0, 8'h00, 9'h000, 3'b110); cyc();
    chk("wr_req", {30'd0, dmem_rd, dmem_wr}, 32'h1);
    idle(); dmem_ack = 1'b1; dmem_rdata = 32'h0001_2345; cyc();
    chk("wr_drop", {30'd0, dmem_rd, dmem_wr}, 32'h0);
    chk("wr_mdr", dmem_wdata, 32'hDEAD_BEEF);
    idle();

    // Stall: H=MAR=0x100, first READ pending, then H=H+1 -> H,TOS,MAR with READ
    load_mdr(32'h100); copy_mdr(9'h101);
    uop(4'd0, 8'h00, 9'h000, 3'b010); cyc();
    uop(4'd0, 8'h39, 9'h141, 3'b010);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stall_hi", {31'd0, stall}, 32'h1);
      cyc();
      chk("stall_mar", dmem_addr, 32'h100);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h55; #1;
    chk("stall_rel", {31'd0, stall}, 32'h0);
    cyc();
    chk("b2b_mar", dmem_addr, 32'h101);
    chk("b2b_mdr", dmem_wdata, 32'h55);
    chk("b2b_req", {31'd0, dmem_rd}, 32'h1);
    idle(); dmem_ack = 1'b1; dmem_rdata = 32'h66; cyc();
    chk("b2b_mdr2", dmem_wdata, 32'h66);
    chk("b2b_drop", {31'd0, dmem_rd}, 32'h0);
    idle();
    peek("stall_h", 4'd0, 1'b1, 32'h101);
    peek("stall_tos", 4'd7, 1'b0, 32'h101);

    // Fetch into MBR, sign/zero extension, JMPC
    load_mdr(32'h10);
    uop(4'd0, 8'h34, 9'h004, 3'b001); cyc();
    chk("f_addr", imem_addr, 32'h10);
    chk("f_req", {31'd0, imem_rd}, 32'h1);
    uop(4'd0, 8'h00, 9'h000, 3'b001); #1;
    chk("f_stall", {31'd0, stall}, 32'h1);
    idle(); imem_ack = 1'b1; imem_rdata = 8'hA7; cyc();
    chk("f_drop", {31'd0, imem_rd}, 32'h0);
    idle();
    peek("mbr_sx", 4'd2, 1'b0, 32'hFFFF_FFA7);
    peek("mbr_zx", 4'd3, 1'b0, 32'h0000_00A7);
    jam = 3'b100; addr_next = 9'h000; #1;
    chk("jmpc", {23'd0, next_addr}, 32'h0A7);
    addr_next = 9'h100; #1;
    chk("jmpc_hi", {23'd0, next_addr}, 32'h1A7);
    idle();

    // Reset during a pending read; a late ack is ignored
    uop(4'd0, 8'h00, 9'h000, 3'b010); cyc();
    chk("rr_req", {31'd0, dmem_rd}, 32'h1);
    idle(); rst = 1'b1; cyc(); rst = 1'b0;
    chk("rr_drop", {31'd0, dmem_rd}, 32'h0);
    chk("rr_mdr0", dmem_wdata, 32'h0);
    dmem_ack = 1'b1; dmem_rdata = 32'h0000_1234; cyc();
    chk("rr_late", dmem_wdata, 32'h0);
    idle(); mem = 3'b010; #1;
    chk("rr_stall", {31'd0, stall}, 32'h0);
    cyc();
    chk("rr_newreq", {31'd0, dmem_rd}, 32'h1);
    idle(); dmem_ack = 1'b1; cyc(); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mic_datapath_p.md
Name: mic_datapath_p

Overview:
Parametrised, handshaked successor of the MIC-1 datapath. Holds the MIC register set (MAR, MDR, PC, MBR, SP, LV, CPP, TOS, OPC, H), B-bus source decode, C-bus write enables, ALU, shifter, N/Z flags and next-microaddress jam logic. Drives two memory ports with registered request/ack handshakes: a data port (word, MAR/MDR) and an instruction port (byte, PC/MBR). Adds a stall output so the control store holds the current microinstruction when a port is busy.

Parameters:
W, 32, datapath/register width (>=16)
IW, 8, MBR / instruction byte width (< W)
AW, 9, microaddress width; JAMN/JAMZ act on bit AW-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
addr_next  in  AW  NEXT_ADDRESS field of the microinstruction
jam  in  3  {JMPC, JAMN, JAMZ}
alu_ctrl  in  8  {SLL8, SRA1, F0, F1, ENA, ENB, INVA, INC}
c_sel  in  9  C-bus write enables {H, OPC, TOS, CPP, LV, SP, PC, MDR, MAR}
mem  in  3  {WRITE, READ, FETCH}
b_sel  in  4  B-bus source code
next_addr  out  AW  next microaddress
stall  out  1  current microinstruction suppressed; controller must hold it
dmem_addr  out  W  = MAR
dmem_wdata  out  W  = MDR
dmem_rd  out  1  data read request
dmem_wr  out  1  data write request
dmem_rdata  in  W  read data, valid with dmem_ack
dmem_ack  in  1  one-cycle completion pulse
imem_addr  out  W  = PC
imem_rd  out  1  fetch request
imem_rdata  in  IW  fetched byte, valid with imem_ack
imem_ack  in  1  one-cycle completion pulse

Behaviour:
- Reset: all registers, N, Z, dmem_rd, dmem_wr, imem_rd, pending flags = 0; stall = 0. Reset mid-access drops the request; any later ack with nothing pending is ignored.
- B-bus: 0 MDR, 1 PC, 2 MBR sign-extended, 3 MBR zero-extended, 4 SP, 5 LV, 6 CPP, 7 TOS, 8 OPC, 9-15 drive 0.
- ALU operands: a = ENA ? H : 0, then inverted if INVA; b = ENB ? busB : 0.
- ALU function by F0F1: 00 a&b; 01 a|b; 10 ~b; 11 a+b+INC mod 2^W. Carry is discarded.
- Shifter: SLL8 gives logical left 8; SRA1 gives arithmetic right 1; both set gives SRA1 applied to the SLL8 result. Shifter output is busC.
- Flags: N = ALU out[W-1] and Z = (ALU out == 0), both pre-shift, registered every non-stalled cycle.
- Registers: each c_sel bit loads busC at the edge. Reading and writing the same register in one cycle returns the old value.
- next_addr is combinational from registered N/Z:
  - bit AW-1 = addr_next[AW-1] | (JAMN&N) | (JAMZ&Z).
  - Low IW bits = addr_next | (JMPC ? MBR : 0).
- Data port:
  - READ or WRITE in cycle t raises dmem_rd or dmem_wr at t+1, using MAR/MDR as updated at edge t.
  - The request stays high until the cycle dmem_ack=1 and drops the next cycle.
  - On a read ack, MDR <= dmem_rdata; this has priority over a same-cycle C-bus MDR write.
  - READ and WRITE set together: treated as WRITE only.
- Instruction port: same protocol with FETCH/imem_rd. On ack, MBR <= imem_rdata.
- Stall: stall = 1 when a new op is issued on a port whose request is pending and not acked this cycle.
  - While stalled, all c_sel writes, flag updates and new requests are suppressed.
  - Acks are still accepted while stalled.
  - Back-to-back ops on a port whose ack arrives in the issue cycle proceed without stall.
- Data and instruction ports operate concurrently and independently.

Test Plan:
- ALU/shifter: H=5, b_sel=4 with SP=3, F0F1=11, ENA=ENB=1 -> busC=8, N=0, Z=0. Same with SRA1 and H=0x80000000, SP=0 -> busC=0xC0000000, N=1.
- INVA+INC: H=7, F0F1=11, ENA=1, INVA=1, INC=1, ENB=0 -> busC=0xFFFFFFF9 (-7). Next cycle with JAMN and addr_next=0x012 -> next_addr=0x112.
- Read handshake: MAR<=0x40 with READ; ack held off 3 cycles, rdata=0xDEADBEEF -> dmem_rd high from t+1 until the ack cycle, dmem_addr=0x40, MDR=0xDEADBEEF after the ack edge.
- Stall: second READ while the first is pending -> stall=1 and TOS write suppressed until the ack cycle; the op then issues once.
- Fetch + JMPC: PC=0x10, FETCH, imem_rdata=0xA7 -> MBR=0xA7. b_sel=2 -> busB=0xFFFFFFA7; b_sel=3 -> 0x000000A7. JMPC with addr_next=0 -> next_addr=0x0A7.
- Reset mid-read: rst during pending read -> dmem_rd=0 next cycle. A late ack leaves MDR=0 and stall=0.
